// File: rtl/tft43_read_timing_if.sv
// Control and panel-pin bundle for the TFT 4.3" 8080-style read engine.
// slave = engine side; master = sequencer plus pad side.
interface tft43_read_timing_if;
  logic        iStart;
  logic [15:0] iCmd;
  logic [7:0]  iCount;
  logic        oBusy;
  logic [15:0] oData;
  logic        oValid;
  logic        oDone;
  logic        LCD_CS;
  logic        LCD_RS;
  logic        LCD_WR;
  logic        LCD_RD;
  logic [15:0] LCD_DATA_O;
  logic        LCD_DATA_OE;
  logic [15:0] LCD_DATA_I;

  modport slave (
    input  iStart, iCmd, iCount, LCD_DATA_I,
    output oBusy, oData, oValid, oDone,
    output LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_O, LCD_DATA_OE
  );

  modport master (
    output iStart, iCmd, iCount, LCD_DATA_I,
    input  oBusy, oData, oValid, oDone,
    input  LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_DATA_O, LCD_DATA_OE
  );
endinterface

// File: rtl/tft43_read_timing.sv
// 8080 read engine: one command write, bus turnaround, then N read strobes.
// Accept-to-done = 2*WR_CYC + (total ? 1 + total*(RD_LOW_CYC+RD_HIGH_CYC) : 0) + 1 clocks.
module tft43_read_timing #(
  parameter int WR_CYC      = 1,
  parameter int RD_LOW_CYC  = 4,
  parameter int RD_HIGH_CYC = 2,
  parameter int DUMMY_READS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tft43_read_timing_if.slave    bus
);

  localparam int PMAX0 = (WR_CYC > RD_LOW_CYC) ? WR_CYC : RD_LOW_CYC;
  localparam int PMAX  = (PMAX0 > RD_HIGH_CYC) ? PMAX0 : RD_HIGH_CYC;
  localparam int PW    = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_WR_L, S_CMD_WR_H, S_TURN, S_RD_L, S_RD_H, S_FINISH
  } state_t;

  state_t      r_state;
  logic [PW-1:0] r_phase;
  logic [9:0]  r_rd_cnt;
  logic [9:0]  r_total;
  logic        r_cs, r_rs, r_wr, r_rd, r_oe;
  logic [15:0] r_data_o;
  logic [15:0] r_odata;
  logic        r_valid, r_done, r_busy;

  logic        w_wr_last, w_rdl_last, w_rdh_last;
  logic [9:0]  w_rd_cnt_nxt;

  assign w_wr_last    = (r_phase == PW'(WR_CYC - 1));
  assign w_rdl_last   = (r_phase == PW'(RD_LOW_CYC - 1));
  assign w_rdh_last   = (r_phase == PW'(RD_HIGH_CYC - 1));
  assign w_rd_cnt_nxt = r_rd_cnt + 10'd1;

  // Every pin is registered; each transition loads the values of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_rd_cnt <= '0;
      r_total  <= '0;
      r_cs     <= 1'b1;
      r_rs     <= 1'b1;
      r_wr     <= 1'b1;
      r_rd     <= 1'b1;
      r_oe     <= 1'b0;
      r_data_o <= '0;
      r_odata  <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.iStart) begin
            r_total  <= 10'(DUMMY_READS) + 10'(bus.iCount);
            r_rd_cnt <= '0;
            r_phase  <= '0;
            r_cs     <= 1'b0;
            r_rs     <= 1'b0;
            r_oe     <= 1'b1;
            r_data_o <= bus.iCmd;
            r_wr     <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_CMD_WR_L;
          end
        end
        S_CMD_WR_L: begin
          if (w_wr_last) begin
            r_phase <= '0;
            r_wr    <= 1'b1;
            r_state <= S_CMD_WR_H;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_CMD_WR_H: begin
          if (w_wr_last) begin
            r_phase  <= '0;
            r_oe     <= 1'b0;
            r_data_o <= '0;
            r_rs     <= 1'b1;
            if (r_total == 10'd0) begin
              r_cs    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_state <= S_TURN;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_TURN: begin
          r_rd    <= 1'b0;
          r_state <= S_RD_L;
        end
        S_RD_L: begin
          if (w_rdl_last) begin
            // Sample on the same edge that releases RD; dummy reads are dropped here.
            r_phase  <= '0;
            r_rd     <= 1'b1;
            r_rd_cnt <= w_rd_cnt_nxt;
            if (r_rd_cnt >= 10'(DUMMY_READS)) begin
              r_odata <= bus.LCD_DATA_I;
              r_valid <= 1'b1;
            end
            r_state  <= S_RD_H;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_RD_H: begin
          if (w_rdh_last) begin
            r_phase <= '0;
            if (r_rd_cnt == r_total) begin
              r_cs    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_rd    <= 1'b0;
              r_state <= S_RD_L;
            end
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        S_FINISH: begin
          r_busy   <= 1'b0;
          r_rd_cnt <= '0;
          r_phase  <= '0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.LCD_CS      = r_cs;
  assign bus.LCD_RS      = r_rs;
  assign bus.LCD_WR      = r_wr;
  assign bus.LCD_RD      = r_rd;
  assign bus.LCD_DATA_O  = r_data_o;
  assign bus.LCD_DATA_OE = r_oe;
  assign bus.oData       = r_odata;
  assign bus.oValid      = r_valid;
  assign bus.oDone       = r_done;
  assign bus.oBusy       = r_busy;

endmodule

// File: tb/tb_tft43_read_timing.sv
// Scoreboard bench for tft43_read_timing with a queue-driven panel model.
module tb_tft43_read_timing;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tft43_read_timing_if bus();
  tft43_read_timing dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] exp_words[$];
  int          exp_lat[$];
  int          exp_falls[$];
  logic [15:0] panel_q[$];
  logic [15:0] exp_cmd = 16'h0;
  logic [15:0] pad_dat = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Panel presents the next queued word on every RD fall.
  assign bus.LCD_DATA_I = pad_dat;
  always @(negedge bus.LCD_RD) begin
    if (rst_n === 1'b1)
      pad_dat = (panel_q.size() != 0) ? panel_q.pop_front() : 16'hDEAD;
  end

  int busy_run = 0, wr_pulses = 0, rd_falls = 0, rd_low_run = 0, inv_viol = 0, done_seen = 0;
  logic prev_rd = 1'b1, prev_wr = 1'b1, prev_oe = 1'b0, prev_busy = 1'b0;
  logic [15:0] last_odata = 16'h0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.oBusy && !prev_busy) begin
        wr_pulses = 0;
        rd_falls  = 0;
      end
      busy_run = bus.oBusy ? busy_run + 1 : 0;
      if (bus.LCD_DATA_OE && !bus.LCD_RD) inv_viol++;
      if (!bus.LCD_WR && !bus.LCD_RD) inv_viol++;
      if (!bus.LCD_WR && (bus.LCD_RS || !bus.LCD_DATA_OE || bus.LCD_CS || bus.LCD_DATA_O != exp_cmd)) inv_viol++;
      if (!bus.LCD_WR && !prev_wr) inv_viol++;
      if (!bus.LCD_RD && (bus.LCD_CS || !bus.LCD_RS)) inv_viol++;
      if (!bus.LCD_WR && prev_wr) wr_pulses++;
      if (!bus.LCD_RD) rd_low_run++;
      if (!bus.LCD_RD && prev_rd) begin
        rd_falls++;
        if (prev_oe) inv_viol++;
      end
      if (bus.LCD_RD && !prev_rd) begin
        check("rd_low_len", rd_low_run, 4);
        rd_low_run = 0;
      end
      if (!bus.oValid && bus.oData !== last_odata) inv_viol++;
      if (bus.oValid) begin
        check("words_pending", exp_words.size() != 0, 1);
        if (exp_words.size() != 0) check("odata", bus.oData, exp_words.pop_front());
        last_odata = bus.oData;
      end
      if (bus.oDone) begin
        check("busy_at_done", bus.oBusy, 1);
        check("lat_pending", exp_lat.size() != 0, 1);
        if (exp_lat.size() != 0) check("latency", busy_run, exp_lat.pop_front());
        if (exp_falls.size() != 0) check("rd_falls", rd_falls, exp_falls.pop_front());
        check("wr_pulses", wr_pulses, 1);
        check("words_left", exp_words.size(), 0);
        check("bus_invariants", inv_viol, 0);
        done_seen++;
      end
      prev_rd   = bus.LCD_RD;
      prev_wr   = bus.LCD_WR;
      prev_oe   = bus.LCD_DATA_OE;
      prev_busy = bus.oBusy;
    end else begin
      prev_rd = 1'b1; prev_wr = 1'b1; prev_oe = 1'b0; prev_busy = 1'b0;
      busy_run = 0; rd_low_run = 0; last_odata = 16'h0;
    end
  end

  task automatic start_txn(input logic [15:0] cmd, input logic [7:0] cnt, input int lat, input int falls);
    exp_cmd = cmd;
    exp_lat.push_back(lat);
    exp_falls.push_back(falls);
    bus.iCmd   = cmd;
    bus.iCount = cnt;
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_seen < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_reached", done_seen, target);
  endtask

  int idle_act;
  int n_done;

  initial begin
    bus.iStart = 1'b0;
    bus.iCmd   = 16'h0;
    bus.iCount = 8'h0;
    rst_n = 1'b0;
    n_done = 0;
    repeat (3) @(negedge clk);
    check("rst_cs", bus.LCD_CS, 1);
    check("rst_rs", bus.LCD_RS, 1);
    check("rst_wr", bus.LCD_WR, 1);
    check("rst_rd", bus.LCD_RD, 1);
    check("rst_oe", bus.LCD_DATA_OE, 0);
    check("rst_datao", bus.LCD_DATA_O, 16'h0);
    check("rst_odata", bus.oData, 16'h0);
    check("rst_flags", {bus.oValid, bus.oDone, bus.oBusy}, 3'b000);
    rst_n = 1'b1;
    idle_act = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.LCD_CS || !bus.LCD_WR || !bus.LCD_RD || bus.LCD_DATA_OE ||
          bus.oValid || bus.oDone || bus.oBusy) idle_act++;
    end
    check("idle_activity", idle_act, 0);

    // ID read: one dummy then three words.
    panel_q = '{16'h0000, 16'h0000, 16'h0094, 16'h0086};
    exp_words = '{16'h0000, 16'h0094, 16'h0086};
    start_txn(16'h00D3, 8'd3, 28, 4);
    n_done++; wait_done(n_done);
    check("odata_hold", bus.oData, 16'h0086);

    // iCount=0 with one dummy read: one RD pulse, no valid.
    panel_q = '{16'h1234};
    start_txn(16'h0029, 8'd0, 10, 1);
    n_done++; wait_done(n_done);
    check("odata_unchanged", bus.oData, 16'h0086);

    // Second iStart mid-read must be ignored.
    panel_q = '{16'hAAAA, 16'h5A5A, 16'hC3C3};
    exp_words = '{16'h5A5A, 16'hC3C3};
    start_txn(16'h002E, 8'd2, 22, 3);
    repeat (8) @(negedge clk);
    bus.iCmd = 16'h0A0A; bus.iCount = 8'd5; bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    n_done++; wait_done(n_done);
    repeat (3) @(negedge clk);
    check("no_requeue_busy", bus.oBusy, 0);

    // Reset during the second RD_L.
    panel_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    start_txn(16'h0004, 8'd3, 0, 0);
    repeat (10) @(negedge clk);
    check("rd_low_before_reset", bus.LCD_RD, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_cs", bus.LCD_CS, 1);
    check("mid_rst_rd", bus.LCD_RD, 1);
    check("mid_rst_oe", bus.LCD_DATA_OE, 0);
    check("mid_rst_busy", bus.oBusy, 0);
    exp_words.delete(); exp_lat.delete(); exp_falls.delete(); panel_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    panel_q = '{16'hFFFF, 16'hBEEF};
    exp_words = '{16'hBEEF};
    start_txn(16'h00D3, 8'd1, 16, 2);
    n_done++; wait_done(n_done);
    check("post_rst_odata", bus.oData, 16'hBEEF);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
